// File: rtl/subgen_pkg.sv
// subgen_pkg: shared defaults, stage-count helper and stage record for subgen_pipe
package subgen_pkg;
    localparam int SUB_SIZE  = 16;
    localparam int SUB_CHUNK = 4;

    function automatic int stages(input int size, input int chunk);
        return size / chunk;
    endfunction

    typedef struct packed {
        logic                valid;
        logic                borrow;
        logic [SUB_SIZE-1:0] res;
        logic [SUB_SIZE-1:0] ra;
        logic [SUB_SIZE-1:0] rb;
    } stage_t;
endpackage

// File: rtl/subgen_chunk.sv
// subgen_chunk: combinational CHUNK-bit ripple-borrow subtractor
//   x, y : chunk operands     bin : borrow in
//   d    : x - y - bin        bout: borrow out
module subgen_chunk
    import subgen_pkg::*;
#(
    parameter int CHUNK = SUB_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);
    logic [CHUNK:0] t;
    assign t    = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
    assign d    = t[CHUNK-1:0];
    assign bout = t[CHUNK];
endmodule

// File: rtl/subgen_pipe.sv
// subgen_pipe: registered borrow-pipelined subtractor, diff = a - b - bi
//   clk, rst (async, active-high)
//   in_valid/in_ready, a, b, bi : operand handshake
//   out_valid/out_ready, diff, bo: result handshake, all outputs from flops
//   SUBGEN_SAT_EN: clamp diff to 0 on underflow (bo still reports 1)
module subgen_pipe
    import subgen_pkg::*;
#(
    parameter int SIZE  = SUB_SIZE,
    parameter int CHUNK = SUB_CHUNK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bi,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bo
);
    localparam int ST = stages(SIZE, CHUNK);

    typedef struct packed {
        logic            valid;
        logic            borrow;
        logic [SIZE-1:0] res;
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;
    } pipe_t;

    pipe_t st [ST+1];
    pipe_t r0;
    logic  adv;

    // the whole pipe moves as one; a stalled output freezes every stage
    assign adv       = out_ready | ~st[ST].valid;
    assign in_ready  = adv;
    assign out_valid = st[ST].valid;
    assign diff      = st[ST].res;
    assign bo        = st[ST].borrow;
    assign st[0]     = r0;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r0 <= '0;
        else if (adv)
            r0 <= '{valid: in_valid, borrow: bi, res: '0, ra: a, rb: b};

    for (genvar s = 1; s <= ST; s++) begin : g_st
        logic [CHUNK-1:0] d;
        logic             bout;
        pipe_t            n;
        pipe_t            r;
        subgen_chunk #(.CHUNK(CHUNK)) u_chunk (
            .x   (st[s-1].ra[CHUNK-1:0]),
            .y   (st[s-1].rb[CHUNK-1:0]),
            .bin (st[s-1].borrow),
            .d   (d),
            .bout(bout)
        );
        // unprocessed operand bits shift down so the next chunk is always at the bottom
        always_comb begin
            n                            = st[s-1];
            n.borrow                     = bout;
            n.res[(s-1)*CHUNK +: CHUNK]  = d;
            n.ra                         = st[s-1].ra >> CHUNK;
            n.rb                         = st[s-1].rb >> CHUNK;
`ifdef SUBGEN_SAT_EN
            if (s == ST && bout)
                n.res = '0;
`endif
        end
        always_ff @(posedge clk or posedge rst)
            if (rst)
                r <= '0;
            else if (adv)
                r <= n;
        assign st[s] = r;
    end
endmodule
